// File: rtl/assert_event_arbiter.sv
// assert_event_arbiter: collects assertion-checker fail pulses, keeps sticky and
// saturating per-source state, and round-robin shares one valid/ready report port.
module assert_event_arbiter #(
  parameter int N_SRC = 4,
  parameter int CNT_W = 8,
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             clear,
  input  logic [N_SRC-1:0] src_fail,
  input  logic [N_SRC-1:0] src_mask,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [IW-1:0]    rpt_src,
  output logic [CNT_W-1:0] rpt_count,
  output logic             any_fail,
  output logic             first_valid,
  output logic [IW-1:0]    first_src,
  output logic             dropped
);
  typedef enum logic [1:0] {IDLE, ARMED, REPORT} state_t;
  state_t                       state_q, state_d;
  logic [N_SRC-1:0]             pending_q, pending_d, hit, hs_mask;
  logic [N_SRC-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]                rr_q, rr_d, rpt_src_q, rpt_src_d, first_src_q, first_src_d;
  logic [IW-1:0]                gnt_idx, first_hit;
  logic [CNT_W-1:0]             rpt_count_q, rpt_count_d;
  logic                         rpt_valid_q, rpt_valid_d, any_fail_q, any_fail_d;
  logic                         first_valid_q, first_valid_d, dropped_q, dropped_d;
  logic                         gnt_found, hs;
  // Scan downwards so the pending index closest to rr_q (and the lowest hit) wins.
  always_comb begin
    gnt_idx = '0;
    gnt_found = 1'b0;
    first_hit = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (pending_q[(int'(rr_q) + k) % N_SRC]) begin
        gnt_found = 1'b1;
        gnt_idx = IW'((int'(rr_q) + k) % N_SRC);
      end
      if (hit[k]) first_hit = IW'(k);
    end
  end
  always_comb begin
    hit = src_fail & src_mask & {N_SRC{arm}};
    hs = rpt_valid_q & rpt_ready;
    hs_mask = hs ? N_SRC'(1) << rpt_src_q : '0;
    pending_d = (pending_q & ~hs_mask) | hit;
    dropped_d = dropped_q | |(hit & pending_q & ~hs_mask);
    any_fail_d = any_fail_q | |hit;
    first_valid_d = first_valid_q | |hit;
    first_src_d = (!first_valid_q && |hit) ? first_hit : first_src_q;
    for (int i = 0; i < N_SRC; i++)
      cnt_d[i] = (hit[i] && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 : cnt_q[i];
    state_d = state_q;
    rr_d = rr_q;
    rpt_valid_d = rpt_valid_q;
    rpt_src_d = rpt_src_q;
    rpt_count_d = rpt_count_q;
    case (state_q)
      IDLE: state_d = arm ? ARMED : IDLE;
      ARMED: begin
        if (!arm) state_d = IDLE;
        else if (gnt_found) begin
          state_d = REPORT;
          rpt_valid_d = 1'b1;
          rpt_src_d = gnt_idx;
          rpt_count_d = cnt_q[gnt_idx];
        end
      end
      REPORT: begin
        if (hs) begin
          rpt_valid_d = 1'b0;
          rr_d = (rpt_src_q == IW'(N_SRC - 1)) ? '0 : rpt_src_q + 1'b1;
          state_d = arm ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      pending_d = '0;
      cnt_d = '0;
      dropped_d = 1'b0;
      any_fail_d = 1'b0;
      first_valid_d = 1'b0;
      first_src_d = '0;
      rr_d = '0;
      rpt_valid_d = 1'b0;
      rpt_src_d = '0;
      rpt_count_d = '0;
      state_d = arm ? ARMED : IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pending_q <= '0;
      cnt_q <= '0;
      rr_q <= '0;
      rpt_valid_q <= 1'b0;
      rpt_src_q <= '0;
      rpt_count_q <= '0;
      any_fail_q <= 1'b0;
      first_valid_q <= 1'b0;
      first_src_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_src_q <= rpt_src_d;
      rpt_count_q <= rpt_count_d;
      any_fail_q <= any_fail_d;
      first_valid_q <= first_valid_d;
      first_src_q <= first_src_d;
      dropped_q <= dropped_d;
    end
  end
  assign rpt_valid = rpt_valid_q;
  assign rpt_src = rpt_src_q;
  assign rpt_count = rpt_count_q;
  assign any_fail = any_fail_q;
  assign first_valid = first_valid_q;
  assign first_src = first_src_q;
  assign dropped = dropped_q;
endmodule

// File: tb/tb_assert_event_arbiter.sv
// tb_assert_event_arbiter: vector table, directed corner sequences and random
// traffic checked against a spec-level reference model.
module tb_assert_event_arbiter;
  logic clk = 1'b0, reset = 1'b0, arm = 1'b0, clear = 1'b0, rpt_ready = 1'b0;
  logic [3:0] src_fail = '0, src_mask = 4'hF;
  logic rpt_valid, any_fail, first_valid, dropped;
  logic [1:0] rpt_src, first_src;
  logic [7:0] rpt_count;
  logic rpt_valid2, any_fail2, first_valid2, dropped2;
  logic [1:0] rpt_src2, first_src2, rpt_count2;
  int nchk = 0, nerr = 0;
  bit m_pend[4], m_valid, m_any, m_fv, m_drop;
  int m_cnt[4], m_rr, m_mode, m_src, m_rcnt, m_first;
  typedef struct {
    logic arm, clr; logic [3:0] fail, mask; logic rdy;
    logic ev; logic [1:0] es; logic [7:0] ec; logic ea, ef; logic [1:0] efs; logic ed;
  } vec_t;
  vec_t vt[13];

  assert_event_arbiter #(.N_SRC(4), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .arm(arm), .clear(clear), .src_fail(src_fail),
    .src_mask(src_mask), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_src(rpt_src),
    .rpt_count(rpt_count), .any_fail(any_fail), .first_valid(first_valid),
    .first_src(first_src), .dropped(dropped));
  assert_event_arbiter #(.N_SRC(4), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .arm(arm), .clear(clear), .src_fail(src_fail),
    .src_mask(src_mask), .rpt_valid(rpt_valid2), .rpt_ready(rpt_ready), .rpt_src(rpt_src2),
    .rpt_count(rpt_count2), .any_fail(any_fail2), .first_valid(first_valid2),
    .first_src(first_src2), .dropped(dropped2));

  always #5 clk = ~clk;

  task automatic chk(string n, int got, int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_cnt[i] = 0; end
    m_valid = 0; m_any = 0; m_fv = 0; m_drop = 0;
    m_rr = 0; m_mode = 0; m_src = 0; m_rcnt = 0; m_first = 0;
  endtask

  // One clock of the specified behaviour, evaluated on the inputs present at the edge.
  task automatic model_step();
    bit hs;
    int g;
    if (!reset) begin model_zero(); return; end
    if (clear) begin model_zero(); m_mode = arm ? 1 : 0; return; end
    hs = m_valid && rpt_ready;
    g = -1;
    for (int k = 0; k < 4; k++) if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    if (m_mode == 0) begin
      if (arm) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!arm) m_mode = 0;
      else if (g >= 0) begin m_mode = 2; m_valid = 1; m_src = g; m_rcnt = m_cnt[g]; end
    end else if (hs) begin
      m_valid = 0; m_pend[m_src] = 0; m_rr = (m_src + 1) % 4; m_mode = arm ? 1 : 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (src_fail[i] && src_mask[i] && arm) begin
        if (m_pend[i]) m_drop = 1;
        m_pend[i] = 1;
        m_any = 1;
        if (m_cnt[i] < 255) m_cnt[i]++;
        if (!m_fv) begin m_fv = 1; m_first = i; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(logic a, logic c, logic [3:0] f, logic [3:0] m, logic r);
    arm = a; clear = c; src_fail = f; src_mask = m; rpt_ready = r;
  endtask

  task automatic chk_model(string n);
    chk({n, "_valid"}, rpt_valid, m_valid);
    chk({n, "_any"}, any_fail, m_any);
    chk({n, "_fv"}, first_valid, m_fv);
    chk({n, "_first"}, first_src, m_first);
    chk({n, "_drop"}, dropped, m_drop);
    if (m_valid) begin
      chk({n, "_src"}, rpt_src, m_src);
      chk({n, "_cnt"}, rpt_count, m_rcnt);
    end
  endtask

  task automatic chk_zero(string n);
    chk({n, "_valid"}, rpt_valid, 0);
    chk({n, "_src"}, rpt_src, 0);
    chk({n, "_cnt"}, rpt_count, 0);
    chk({n, "_any"}, any_fail, 0);
    chk({n, "_fv"}, first_valid, 0);
    chk({n, "_first"}, first_src, 0);
    chk({n, "_drop"}, dropped, 0);
  endtask

  initial begin
    //          arm   clr   fail  mask  rdy   ev    es    ec    ea    ef    efs   ed
    vt[0]  = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 4'h2, 4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 2'd1, 8'd1, 1'b1, 1'b1, 2'd1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 4'hB, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 2'd0, 8'd1, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 2'd1, 8'd1, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 2'd3, 8'd1, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd0, 1'b0};
    model_zero();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].arm, vt[i].clr, vt[i].fail, vt[i].mask, vt[i].rdy);
      tick();
      chk($sformatf("v%0d_valid", i), rpt_valid, vt[i].ev);
      chk($sformatf("v%0d_any", i), any_fail, vt[i].ea);
      chk($sformatf("v%0d_fv", i), first_valid, vt[i].ef);
      chk($sformatf("v%0d_first", i), first_src, vt[i].efs);
      chk($sformatf("v%0d_drop", i), dropped, vt[i].ed);
      if (vt[i].ev) begin
        chk($sformatf("v%0d_src", i), rpt_src, vt[i].es);
        chk($sformatf("v%0d_cnt", i), rpt_count, vt[i].ec);
      end
    end
    // Stalled report: count frozen, repeats set dropped, handshake-cycle hit keeps pending.
    drive(1, 1, 4'h0, 4'hF, 0); tick();
    drive(1, 0, 4'h4, 4'hF, 0); tick();
    drive(1, 0, 4'h0, 4'hF, 0); tick();
    chk("stall_valid", rpt_valid, 1); chk("stall_src", rpt_src, 2); chk("stall_cnt", rpt_count, 1);
    drive(1, 0, 4'h4, 4'hF, 0); tick(); tick();
    chk("stall_drop", dropped, 1); chk("stall_frozen", rpt_count, 1);
    drive(1, 0, 4'h4, 4'hF, 1); tick();
    chk("stall_hs_valid", rpt_valid, 0);
    drive(1, 0, 4'h0, 4'hF, 0); tick();
    chk("stall_rerpt_src", rpt_src, 2); chk("stall_rerpt_cnt", rpt_count, 4);
    drive(1, 0, 4'h0, 4'hF, 1); tick(); tick();
    chk("stall_done", rpt_valid, 0);
    // Saturation: src 3 fails five times while src 0 holds the report channel.
    drive(1, 1, 4'h0, 4'hF, 0); tick();
    drive(1, 0, 4'h1, 4'hF, 0); tick();
    drive(1, 0, 4'h0, 4'hF, 0); tick();
    drive(1, 0, 4'h8, 4'hF, 0); repeat (5) tick();
    drive(1, 0, 4'h0, 4'hF, 1); tick();
    drive(1, 0, 4'h0, 4'hF, 0); tick();
    chk("sat_src", rpt_src, 3); chk("sat_cnt8", rpt_count, 5);
    chk("sat_src2", rpt_src2, 3); chk("sat_cnt2", rpt_count2, 3);
    drive(1, 0, 4'h0, 4'hF, 1); tick();
    // Disarm during a report: it completes, later fails ignored, residue reported on re-arm.
    drive(1, 1, 4'h0, 4'hF, 0); tick();
    drive(1, 0, 4'h3, 4'hF, 0); tick();
    drive(1, 0, 4'h0, 4'hF, 0); tick();
    chk("dis_src", rpt_src, 0);
    drive(0, 0, 4'h4, 4'hF, 1); tick();
    chk("dis_hs", rpt_valid, 0);
    tick();
    chk("dis_idle", rpt_valid, 0);
    drive(1, 0, 4'h0, 4'hF, 0); tick();
    chk("rearm_wait", rpt_valid, 0);
    tick();
    chk("rearm_valid", rpt_valid, 1); chk("rearm_src", rpt_src, 1); chk("rearm_cnt", rpt_count, 1);
    drive(1, 0, 4'h0, 4'hF, 1); tick(); tick(); tick();
    chk("rearm_empty", rpt_valid, 0);
    // Clear coincident with a hit and a handshake.
    drive(1, 1, 4'h0, 4'hF, 0); tick();
    drive(1, 0, 4'h1, 4'hF, 0); tick();
    drive(1, 0, 4'h0, 4'hF, 0); tick();
    chk("clr_pre", rpt_valid, 1);
    drive(1, 1, 4'h1, 4'hF, 1); tick();
    chk_zero("clr");
    drive(1, 0, 4'h0, 4'hF, 0); tick(); tick();
    chk("clr_noreport", rpt_valid, 0);
    // Asynchronous reset while a report is valid.
    drive(1, 0, 4'h2, 4'hF, 0); tick();
    drive(1, 0, 4'h0, 4'hF, 0); tick();
    chk("ar_pre", rpt_valid, 1);
    reset = 1'b0;
    #1;
    chk_zero("areset");
    model_zero();
    tick();
    reset = 1'b1;
    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 8) != 0, ($urandom % 50) == 0, 4'($urandom), 4'($urandom | $urandom),
            ($urandom % 3) != 0);
      tick();
      chk_model($sformatf("rnd%0d", n));
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
